// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Line geometry: 16-byte lines, 64 lines, 64-bit physical fetch addresses.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        FILL    = 2'd2,
        INSTALL = 2'd3
    } state_t;

    localparam int OFF_W = 4;
    localparam int IDX_W = 6;
    localparam int TAG_W = 54;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    localparam logic [63:0] EXEC_BASE_DEF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] EXEC_SIZE_DEF = 64'h0000_0000_0010_0000;

endpackage

// File: rtl/icache_data_array.sv
// Instruction line storage: one full-line write port, combinational read port.
// Tags and valid bits live in the controller.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int LINE_W = 128
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem_reg [LINES];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with a single-line refill engine.
// Define ICACHE_PERF_EN to add saturating PERF_HITS / PERF_MISSES counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int          LINES      = 64,
    parameter int          LINE_BYTES = 16,
    parameter logic [63:0] EXEC_BASE  = EXEC_BASE_DEF,
    parameter logic [63:0] EXEC_SIZE  = EXEC_SIZE_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] FE_PC,
    input  logic        FE_REQ,
    input  logic        FLUSH,
    output logic        ICACHE_R,
    output logic [31:0] INSTRUCTION,
    output logic        ICACHE_AF,
    output logic        MEM_REQ,
    output logic [63:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic        MEM_RVALID,
    input  logic [63:0] MEM_RDATA
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] PERF_HITS,
    output logic [31:0] PERF_MISSES
`endif
);

    localparam int   LINE_W    = LINE_BYTES * 8;
    localparam int   WORDS     = LINE_BYTES / 4;
    localparam int   BEATS     = LINE_BYTES / 8;
    localparam logic BEAT_LAST = 1'(BEATS - 1);

    state_t state_reg, state_next;

    logic [63:0]      mem_addr_reg;
    logic             beat_cnt_reg;
    logic             drop_reg;
    logic [63:0]      beat_buf_reg [BEATS];
    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_reg [LINES];

    logic [IDX_W-1:0]  pc_idx, fill_idx;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic [LINE_W-1:0] line_rdata, line_wdata;
    logic [31:0]       line_words [WORDS];
    logic              hit_raw, aligned, miss_start, in_refill, install_we;

    assign pc_idx   = FE_PC[OFF_W +: IDX_W];
    assign pc_tag   = FE_PC[63 -: TAG_W];
    assign fill_idx = mem_addr_reg[OFF_W +: IDX_W];
    assign fill_tag = mem_addr_reg[63 -: TAG_W];

    assign ICACHE_AF = (FE_PC < EXEC_BASE) || (FE_PC >= EXEC_BASE + EXEC_SIZE);
    assign aligned   = (FE_PC[1:0] == 2'b00);
    assign hit_raw   = valid_reg[pc_idx] && (tag_reg[pc_idx] == pc_tag);

    // Only IDLE serves hits, so a redirected PC is looked up after the refill.
    assign ICACHE_R   = FE_REQ && hit_raw && !ICACHE_AF && aligned && (state_reg == IDLE);
    assign miss_start = FE_REQ && !hit_raw && !ICACHE_AF && aligned;
    assign in_refill  = (state_reg == REQ) || (state_reg == FILL);
    assign install_we = (state_reg == INSTALL);

    assign MEM_REQ  = (state_reg == REQ);
    assign MEM_ADDR = mem_addr_reg;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_words[gi] = line_rdata[32*gi +: 32];
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign line_wdata[64*gi +: 64] = beat_buf_reg[gi];
    end

    assign INSTRUCTION = ICACHE_R ? line_words[FE_PC[3:2]] : NOP_INSN;

    icache_data_array #(
        .LINES  (LINES),
        .LINE_W (LINE_W)
    ) u_data (
        .CLK   (CLK),
        .we    (install_we),
        .waddr (fill_idx),
        .wdata (line_wdata),
        .raddr (pc_idx),
        .rdata (line_rdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (miss_start) state_next = REQ;
            REQ:     if (MEM_ACK) state_next = FILL;
            FILL:    if (MEM_RVALID && (beat_cnt_reg == BEAT_LAST)) state_next = INSTALL;
            INSTALL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            beat_cnt_reg <= 1'b0;
            drop_reg     <= 1'b0;
            beat_buf_reg <= '{default: '0};
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && miss_start) begin
                mem_addr_reg <= {FE_PC[63:OFF_W], {OFF_W{1'b0}}};
                beat_cnt_reg <= 1'b0;
            end
            if ((state_reg == FILL) && MEM_RVALID) begin
                beat_buf_reg[beat_cnt_reg] <= MEM_RDATA;
                beat_cnt_reg               <= beat_cnt_reg + 1'b1;
            end
            // A flush racing an in-flight refill must not resurrect stale code.
            if (state_next == IDLE) begin
                drop_reg <= 1'b0;
            end else if (FLUSH && in_refill) begin
                drop_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_reg <= '0;
        end else if (FLUSH) begin
            valid_reg <= '0;
        end else if (install_we && !drop_reg) begin
            valid_reg[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (install_we) begin
            tag_reg[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_reg, perf_misses_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_hits_reg   <= '0;
            perf_misses_reg <= '0;
        end else begin
            if (ICACHE_R && (perf_hits_reg != 32'hFFFF_FFFF)) begin
                perf_hits_reg <= perf_hits_reg + 32'd1;
            end
            if ((state_reg == IDLE) && (state_next == REQ) && (perf_misses_reg != 32'hFFFF_FFFF)) begin
                perf_misses_reg <= perf_misses_reg + 32'd1;
            end
        end
    end

    assign PERF_HITS   = perf_hits_reg;
    assign PERF_MISSES = perf_misses_reg;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: stimulus queues expected hits and line
// requests, a monitor pops and compares them as the cache presents them.
module tb_icache_ctrl;

    logic        CLK;
    logic        RESET;
    logic [63:0] FE_PC;
    logic        FE_REQ;
    logic        FLUSH;
    logic        ICACHE_R;
    logic [31:0] INSTRUCTION;
    logic        ICACHE_AF;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic        MEM_ACK;
    logic        MEM_RVALID;
    logic [63:0] MEM_RDATA;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    icache_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FE_PC       (FE_PC),
        .FE_REQ      (FE_REQ),
        .FLUSH       (FLUSH),
        .ICACHE_R    (ICACHE_R),
        .INSTRUCTION (INSTRUCTION),
        .ICACHE_AF   (ICACHE_AF),
        .MEM_REQ     (MEM_REQ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_ACK     (MEM_ACK),
        .MEM_RVALID  (MEM_RVALID),
        .MEM_RDATA   (MEM_RDATA)
`ifdef ICACHE_PERF_EN
        ,
        .PERF_HITS   (perf_hits),
        .PERF_MISSES (perf_misses)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } hit_t;

    hit_t        exp_hit_q [$];
    logic [63:0] exp_addr_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: line 0x8000_0000 holds the reference program, every
    // other word is its own address with the upper half XORed by 0xA5A5.
    function automatic logic [63:0] mem_beat(input logic [63:0] line, input int b);
        logic [63:0] a;
        logic [31:0] lo, hi;
        if (line == 64'h8000_0000) begin
            return (b == 0) ? 64'h00000093_00000013 : 64'h00300193_00200113;
        end
        a  = line + 64'(8 * b);
        lo = a[31:0] ^ 32'hA5A5_0000;
        hi = (a[31:0] + 32'd4) ^ 32'hA5A5_0000;
        return {hi, lo};
    endfunction

    // Memory responder: accepts every request at once, then streams two beats.
    initial begin
        logic [63:0] fill_addr;
        int          beats_left;
        MEM_ACK    = 1'b0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        fill_addr  = '0;
        beats_left = 0;
        forever begin
            @(negedge CLK);
            if (MEM_ACK) begin
                fill_addr  = MEM_ADDR;
                beats_left = 2;
            end
            MEM_ACK    = MEM_REQ;
            MEM_RVALID = 1'b0;
            if (beats_left > 0) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = mem_beat(fill_addr, 2 - beats_left);
                beats_left--;
            end
        end
    end

    // Monitor: every hit and every new line request must match the scoreboard.
    initial begin
        hit_t        e;
        logic [63:0] ea;
        logic        req_seen;
        req_seen = 1'b0;
        forever begin
            @(negedge CLK);
            if (ICACHE_R) begin
                if (exp_hit_q.size() == 0) begin
                    chk("unexpected_hit_pc", FE_PC, 64'hDEAD);
                end else begin
                    e = exp_hit_q.pop_front();
                    chk("hit_pc", FE_PC, e.pc);
                    chk("hit_insn", {32'h0, INSTRUCTION}, {32'h0, e.insn});
                    $display("hit  pc=%h insn=%h", FE_PC, INSTRUCTION);
                end
            end
            if (MEM_REQ && !req_seen) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_mem_req", MEM_ADDR, 64'hDEAD);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", MEM_ADDR, ea);
                    $display("req  addr=%h", MEM_ADDR);
                end
            end
            req_seen = MEM_REQ;
        end
    end

    task automatic fetch(input string name, input logic [63:0] pc, input logic [31:0] insn,
                         input int exp_lat, input int flush_cyc, input int refills);
        int   n;
        logic got;
        for (int i = 0; i < refills; i++) exp_addr_q.push_back({pc[63:4], 4'h0});
        exp_hit_q.push_back('{pc: pc, insn: insn});
        @(posedge CLK);
        #1;
        FE_PC  = pc;
        FE_REQ = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            FLUSH = (n == flush_cyc);
            @(negedge CLK);
            if (ICACHE_R) begin
                got = 1'b1;
            end else begin
                @(posedge CLK);
                #1;
                n++;
            end
        end
        FLUSH = 1'b0;
        chk({name, "_latency"}, got ? 64'(n) : 64'd999, 64'(exp_lat));
        if (!got && exp_hit_q.size() > 0) exp_hit_q.delete(exp_hit_q.size() - 1);
        @(posedge CLK);
        #1;
        FE_REQ = 1'b0;
    endtask

    task automatic probe(input string name, input logic [63:0] pc, input logic req,
                         input logic exp_af);
        @(posedge CLK);
        #1;
        FE_PC  = pc;
        FE_REQ = req;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk({name, "_af"}, {63'h0, ICACHE_AF}, {63'h0, exp_af});
            chk({name, "_r"}, {63'h0, ICACHE_R}, 64'h0);
        end
        $display("probe pc=%h af=%b r=%b", pc, ICACHE_AF, ICACHE_R);
        @(posedge CLK);
        #1;
        FE_REQ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET  = 1'b0;
        FE_PC  = 64'h8000_0000;
        FE_REQ = 1'b1;
        FLUSH  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_icache_r", {63'h0, ICACHE_R}, 64'h0);
        chk("reset_mem_req", {63'h0, MEM_REQ}, 64'h0);
        chk("reset_mem_addr", MEM_ADDR, 64'h0);
        FE_REQ = 1'b0;
        RESET  = 1'b1;

        fetch("miss0",      64'h8000_0000, 32'h00000013,  5, -1, 1);
        fetch("hit_c",      64'h8000_000C, 32'h00300193,  0, -1, 0);
        fetch("hit_4",      64'h8000_0004, 32'h00000093,  0, -1, 0);
        fetch("evict",      64'h8000_0400, 32'h25A50400,  5, -1, 1);
        fetch("hit_408",    64'h8000_0408, 32'h25A50408,  0, -1, 0);
        fetch("remiss0",    64'h8000_0000, 32'h00000013,  5, -1, 1);
        fetch("line1",      64'h8000_0010, 32'h25A50010,  5, -1, 1);
        fetch("flush_fill", 64'h8000_0400, 32'h25A50400, 10,  2, 2);
        fetch("post_flush", 64'h8000_0010, 32'h25A50010,  5, -1, 1);

        probe("af_low",     64'h0000_1000, 1'b1, 1'b1);
        probe("af_noreq",   64'h0000_1000, 1'b0, 1'b1);
        probe("af_below",   64'h7FFF_FFFC, 1'b1, 1'b1);
        probe("af_end",     64'h8010_0000, 1'b1, 1'b1);
        probe("last_word",  64'h800F_FFFC, 1'b0, 1'b0);
        probe("misalign2",  64'h8000_0002, 1'b1, 1'b0);
        probe("misalign12", 64'h8000_0012, 1'b1, 1'b0);

        // Reset while the refill of line 0x8000_0020 is in its first beat.
        exp_addr_q.push_back(64'h8000_0020);
        @(posedge CLK);
        #1;
        FE_PC  = 64'h8000_0020;
        FE_REQ = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        RESET  = 1'b0;
        FE_REQ = 1'b0;
        #1;
        chk("rst_fill_mem_req", {63'h0, MEM_REQ}, 64'h0);
        chk("rst_fill_mem_addr", MEM_ADDR, 64'h0);
        chk("rst_fill_icache_r", {63'h0, ICACHE_R}, 64'h0);
        $display("reset during fill");
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        chk("rst_idle_mem_req", {63'h0, MEM_REQ}, 64'h0);

        fetch("post_rst_1", 64'h8000_0010, 32'h25A50010, 5, -1, 1);
        fetch("post_rst_2", 64'h8000_0028, 32'h25A50028, 5, -1, 1);

        repeat (4) @(negedge CLK);
        chk("hit_queue_drained", 64'(exp_hit_q.size()), 64'h0);
        chk("addr_queue_drained", 64'(exp_addr_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
